// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_pkg
//  Description : Shared types for the two-master Wishbone arbiter.
//                Holds the arbiter state encoding, the owner-index width and
//                a helper that maps a state onto the one-hot debug grant.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    // Width of the registered "last owner" index (two masters -> one bit).
    localparam int c_OWNER_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } arb_state_t;

    // One-hot owner view of the state; bit0 = master 0.
    function automatic logic [1:0] state_to_grant(input arb_state_t s);
        case (s)
            ST_GRANT0: return 2'b01;
            ST_GRANT1: return 2'b10;
            default:   return 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arb_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arb_rr_grant
//  Description : Cycle-held round-robin grant FSM for two Wishbone masters.
//                A grant lasts for the owner's whole bus cycle; on contention
//                the master that did not own the bus last wins.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   clock
//    rst      in   synchronous active-high reset
//    i_cyc0   in   master 0 cycle request
//    i_cyc1   in   master 1 cycle request
//    o_state  out  current arbiter state
//    o_grant  out  one-hot owner (bit0 = master 0)
// ============================================================================
module wb_arb_rr_grant
    import wb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cyc0,
    input  logic       i_cyc1,
    output arb_state_t o_state,
    output logic [1:0] o_grant
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [c_OWNER_W-1:0]   r_last_owner;
    logic [c_OWNER_W-1:0]   w_last_owner_nxt;

    // State register. last_owner resets to master 1 so master 0 wins the
    // first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= c_OWNER_W'(1);
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;
        case (r_state)
            ST_IDLE: begin
                if (i_cyc0 && i_cyc1) begin
                    w_state_nxt = (r_last_owner == c_OWNER_W'(0)) ? ST_GRANT1 : ST_GRANT0;
                end else if (i_cyc0) begin
                    w_state_nxt = ST_GRANT0;
                end else if (i_cyc1) begin
                    w_state_nxt = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                // Hand straight over to a waiting master: no idle gap, and a
                // re-asserting owner loses to the waiter.
                if (!i_cyc0) begin
                    w_last_owner_nxt = c_OWNER_W'(0);
                    w_state_nxt      = i_cyc1 ? ST_GRANT1 : ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (!i_cyc1) begin
                    w_last_owner_nxt = c_OWNER_W'(1);
                    w_state_nxt      = i_cyc0 ? ST_GRANT0 : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        o_grant = state_to_grant(r_state);
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter2
//  Description : Two-master / one-slave Wishbone arbiter in front of the RAM
//                controller. Master 0 is the CPU bus bridge, master 1 the
//                MCU/SPI bridge. Whole bus cycles are granted, round-robin on
//                contention; address/data/we/strobe are muxed to the slave and
//                ack/read data are returned to the owner only.
//  Revision    : 1.0 - initial release
//
//  Optional feature macro: WB_ARBITER_TIMEOUT_EN
//    When defined, an ack watchdog returns a one-cycle ack with all-ones data
//    to an owner stalled TIMEOUT_CYCLES cycles and sets sticky timeout_o.
//    When undefined, timeout_o is tied low and a stalled slave stalls forever.
//
//  Ports
//    wb_clock_i, wb_reset_i          clock, synchronous active-high reset
//    m{0,1}_addr_i/_data_i/_we_i     master address, write data, write enable
//    m{0,1}_cycle_i/_strobe_i        master bus request / transfer strobe
//    m{0,1}_data_o/_ack_o            read data, ack (owner only)
//    s_addr_o/_data_o/_we_o          to the RAM controller
//    s_cycle_o/_strobe_o             to the RAM controller
//    s_data_i/_ack_i                 from the RAM controller
//    grant_o                         one-hot current owner (bit0 = m0)
//    timeout_o                       sticky watchdog flag
// ============================================================================
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 17,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    input  logic                  m0_we_i,
    input  logic                  m0_cycle_i,
    input  logic                  m0_strobe_i,
    output logic                  m0_ack_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    input  logic                  m1_we_i,
    input  logic                  m1_cycle_i,
    input  logic                  m1_strobe_i,
    output logic                  m1_ack_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_we_o,
    output logic                  s_cycle_o,
    output logic                  s_strobe_o,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    arb_state_t w_state;
    logic       w_own_cyc;   // current owner's cycle request
    logic       w_own_stb;   // current owner is strobing
    logic       w_fire;      // watchdog expires this cycle

    wb_arb_rr_grant u_grant (
        .clk     (wb_clock_i),
        .rst     (wb_reset_i),
        .i_cyc0  (m0_cycle_i),
        .i_cyc1  (m1_cycle_i),
        .o_state (w_state),
        .o_grant (grant_o)
    );

    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        case (w_state)
            ST_GRANT0: begin
                w_own_cyc = m0_cycle_i;
                w_own_stb = m0_cycle_i && m0_strobe_i;
            end
            ST_GRANT1: begin
                w_own_cyc = m1_cycle_i;
                w_own_stb = m1_cycle_i && m1_strobe_i;
            end
            default: begin
                w_own_cyc = 1'b0;
                w_own_stb = 1'b0;
            end
        endcase
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_wd_cnt;
    logic               r_timeout;

    assign w_fire = w_own_stb && !s_ack_i && (r_wd_cnt == c_CNT_W'(TIMEOUT_CYCLES));

    // Counts stalled strobe cycles of the current owner. Leaving the grant
    // (owner cycle low, including IDLE) clears it, so each new grant starts
    // from zero; an ack or the synthetic timeout ack also restarts it.
    always_ff @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_own_cyc || s_ack_i || w_fire) begin
                r_wd_cnt <= '0;
            end else if (w_own_stb) begin
                r_wd_cnt <= r_wd_cnt + c_CNT_W'(1);
            end
            if (w_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Flag is visible in the same cycle as the synthetic ack.
    assign timeout_o = r_timeout || w_fire;
`else
    logic w_unused_timeout;

    assign w_fire           = 1'b0;
    assign timeout_o        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Slave-side mux and ack routing. During a watchdog expiry the slave sees
    // the cycle dropped while the owner receives the synthetic ack.
    always_comb begin
        s_addr_o   = '0;
        s_data_o   = '0;
        s_we_o     = 1'b0;
        s_strobe_o = 1'b0;
        s_cycle_o  = 1'b0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        case (w_state)
            ST_GRANT0: begin
                s_addr_o   = m0_addr_i;
                s_data_o   = m0_data_i;
                s_we_o     = m0_we_i;
                s_strobe_o = m0_strobe_i && !w_fire;
                s_cycle_o  = m0_cycle_i && !w_fire;
                m0_ack_o   = s_ack_i || w_fire;
            end
            ST_GRANT1: begin
                s_addr_o   = m1_addr_i;
                s_data_o   = m1_data_i;
                s_we_o     = m1_we_i;
                s_strobe_o = m1_strobe_i && !w_fire;
                s_cycle_o  = m1_cycle_i && !w_fire;
                m1_ack_o   = s_ack_i || w_fire;
            end
            default: begin
                s_addr_o = '0;
            end
        endcase
    end

    // Both masters see the slave read data; only the owner sees an ack.
    assign m0_data_o = w_fire ? {DATA_WIDTH{1'b1}} : s_data_i;
    assign m1_data_o = w_fire ? {DATA_WIDTH{1'b1}} : s_data_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter2
//  Description : Directed self-checking bench for wb_arbiter2 with a small
//                single-cycle-ack RAM model on the slave port. The watchdog
//                test is compiled only with WB_ARBITER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

    logic        wb_clock_i = 1'b0;
    logic        wb_reset_i;
    logic [16:0] m0_addr_i, m1_addr_i, s_addr_o;
    logic [7:0]  m0_data_i, m1_data_i, m0_data_o, m1_data_o;
    logic [7:0]  s_data_o, s_data_i;
    logic        m0_we_i, m0_cycle_i, m0_strobe_i, m0_ack_o;
    logic        m1_we_i, m1_cycle_i, m1_strobe_i, m1_ack_o;
    logic        s_we_o, s_cycle_o, s_strobe_o, s_ack_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    logic        stall;
    logic [7:0]  mem [0:255];
    int          m1_ack_cnt = 0;

    always #5 wb_clock_i = ~wb_clock_i;

    wb_arbiter2 #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (17),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .wb_clock_i  (wb_clock_i),
        .wb_reset_i  (wb_reset_i),
        .m0_addr_i   (m0_addr_i),
        .m0_data_i   (m0_data_i),
        .m0_data_o   (m0_data_o),
        .m0_we_i     (m0_we_i),
        .m0_cycle_i  (m0_cycle_i),
        .m0_strobe_i (m0_strobe_i),
        .m0_ack_o    (m0_ack_o),
        .m1_addr_i   (m1_addr_i),
        .m1_data_i   (m1_data_i),
        .m1_data_o   (m1_data_o),
        .m1_we_i     (m1_we_i),
        .m1_cycle_i  (m1_cycle_i),
        .m1_strobe_i (m1_strobe_i),
        .m1_ack_o    (m1_ack_o),
        .s_addr_o    (s_addr_o),
        .s_data_o    (s_data_o),
        .s_data_i    (s_data_i),
        .s_we_o      (s_we_o),
        .s_cycle_o   (s_cycle_o),
        .s_strobe_o  (s_strobe_o),
        .s_ack_i     (s_ack_i),
        .grant_o     (grant_o),
        .timeout_o   (timeout_o)
    );

    // RAM model: registered single-cycle ack, suppressed while stall is high.
    always @(posedge wb_clock_i) begin
        if (wb_reset_i) begin
            s_ack_i <= 1'b0;
        end else if (s_cycle_o && s_strobe_o && !s_ack_i && !stall) begin
            s_ack_i <= 1'b1;
            if (s_we_o) mem[s_addr_o[7:0]] <= s_data_o;
            s_data_i <= s_we_o ? 8'h00 : mem[s_addr_o[7:0]];
        end else begin
            s_ack_i <= 1'b0;
        end
    end

    always @(negedge wb_clock_i) begin
        if (m1_ack_o) m1_ack_cnt <= m1_ack_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [16:0] a, input logic [7:0] d);
        if (m == 0) begin
            m0_cycle_i = cyc; m0_strobe_i = stb; m0_we_i = we; m0_addr_i = a; m0_data_i = d;
        end else begin
            m1_cycle_i = cyc; m1_strobe_i = stb; m1_we_i = we; m1_addr_i = a; m1_data_i = d;
        end
    endtask

    // Single transfer from one master, bounded wait for its ack.
    task automatic xfer(input int m, input logic we, input logic [16:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output logic [1:0] g, output logic ok);
        rd = 'x;
        g  = 'x;
        ok = 1'b0;
        drv(m, 1'b1, 1'b1, we, a, wd);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge wb_clock_i);
            if ((m == 0) ? m0_ack_o : m1_ack_o) begin
                ok = 1'b1;
                rd = (m == 0) ? m0_data_o : m1_data_o;
                g  = grant_o;
            end
        end
        drv(m, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        @(negedge wb_clock_i);
    endtask

    initial begin
        logic [7:0] rd;
        logic [1:0] g;
        logic       ok;
        logic [1:0] glog [0:15];
        int         n, c0, c1, base;
        logic       a0, a1, h0, h1;

        wb_reset_i = 1'b1;
        stall      = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        repeat (3) @(negedge wb_clock_i);
        wb_reset_i = 1'b0;

        // Reset state
        check("rst_grant",   grant_o,    2'b00);
        check("rst_scyc",    s_cycle_o,  1'b0);
        check("rst_sstb",    s_strobe_o, 1'b0);
        check("rst_swe",     s_we_o,     1'b0);
        check("rst_saddr",   s_addr_o,   17'h0);
        check("rst_sdata",   s_data_o,   8'h0);
        check("rst_acks",    {m1_ack_o, m0_ack_o}, 2'b00);
        check("rst_timeout", timeout_o,  1'b0);

        // Strobe without cycle is ignored
        m0_strobe_i = 1'b1;
        repeat (2) @(negedge wb_clock_i);
        check("stb_only_grant", grant_o,    2'b00);
        check("stb_only_sstb",  s_strobe_o, 1'b0);
        m0_strobe_i = 1'b0;
        @(negedge wb_clock_i);

        // Test 1: m0 write then read, m1 idle
        base = m1_ack_cnt;
        xfer(0, 1'b1, 17'h055, 8'h55, rd, g, ok);
        check("t1_wr_ack",   ok, 1'b1);
        check("t1_wr_grant", g,  2'b01);
        xfer(0, 1'b0, 17'h055, 8'h00, rd, g, ok);
        check("t1_rd_ack",   ok, 1'b1);
        check("t1_rd_grant", g,  2'b01);
        check("t1_rd_data",  rd, 8'h55);
        check("t1_m1_ack_none", m1_ack_cnt - base, 0);

        // Test 2: simultaneous requests straight after reset
        wb_reset_i = 1'b1;
        @(negedge wb_clock_i);
        wb_reset_i = 1'b0;
        drv(0, 1'b1, 1'b1, 1'b1, 17'h010, 8'hA1);
        drv(1, 1'b1, 1'b1, 1'b1, 17'h011, 8'hB2);
        @(negedge wb_clock_i);
        check("t2_first_grant", grant_o,  2'b01);
        check("t2_first_addr",  s_addr_o, 17'h010);
        check("t2_first_data",  s_data_o, 8'hA1);
        check("t2_m1_wait_ack", m1_ack_o, 1'b0);
        @(negedge wb_clock_i);
        check("t2_m0_ack", m0_ack_o, 1'b1);
        drv(0, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        @(negedge wb_clock_i);
        check("t2_handover_grant", grant_o,  2'b10);
        check("t2_handover_addr",  s_addr_o, 17'h011);
        @(negedge wb_clock_i);
        check("t2_m1_ack", m1_ack_o, 1'b1);
        drv(1, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        @(negedge wb_clock_i);
        check("t2_idle_grant", grant_o, 2'b00);
        xfer(0, 1'b0, 17'h010, 8'h00, rd, g, ok);
        check("t2_rb_10", rd, 8'hA1);
        xfer(1, 1'b0, 17'h011, 8'h00, rd, g, ok);
        check("t2_rb_11", rd, 8'hB2);

        // Test 3: both masters request repeatedly, 4 transfers each
        n = 0; c0 = 0; c1 = 0;
        a0 = 1'b0; a1 = 1'b0; h0 = 1'b0; h1 = 1'b0;
        for (int cyc = 0; cyc < 100 && !(c0 == 4 && c1 == 4); cyc++) begin
            if (a0) begin
                if (m0_ack_o) begin
                    if (n < 16) glog[n] = grant_o;
                    n++; c0++; a0 = 1'b0; h0 = 1'b1;
                    drv(0, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
                end
            end else if (h0) begin
                h0 = 1'b0;
            end else if (c0 < 4) begin
                drv(0, 1'b1, 1'b1, 1'b1, 17'(32'h20 + c0), 8'(32'hC0 + c0));
                a0 = 1'b1;
            end
            if (a1) begin
                if (m1_ack_o) begin
                    if (n < 16) glog[n] = grant_o;
                    n++; c1++; a1 = 1'b0; h1 = 1'b1;
                    drv(1, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
                end
            end else if (h1) begin
                h1 = 1'b0;
            end else if (c1 < 4) begin
                drv(1, 1'b1, 1'b1, 1'b1, 17'(32'h30 + c1), 8'(32'hD0 + c1));
                a1 = 1'b1;
            end
            @(negedge wb_clock_i);
        end
        check("t3_done", {c0 == 4, c1 == 4}, 2'b11);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_grant_%0d", i), glog[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        xfer(0, 1'b0, 17'h033, 8'h00, rd, g, ok);
        check("t3_rb_33", rd, 8'hD3);
        xfer(1, 1'b0, 17'h022, 8'h00, rd, g, ok);
        check("t3_rb_22", rd, 8'hC2);

        // Test 4: reset pulse while m1 is mid-transfer
        stall = 1'b1;
        drv(1, 1'b1, 1'b1, 1'b0, 17'h040, 8'h00);
        @(negedge wb_clock_i);
        check("t4_grant1", grant_o, 2'b10);
        @(negedge wb_clock_i);
        check("t4_mid_scyc", s_cycle_o, 1'b1);
        wb_reset_i = 1'b1;
        @(negedge wb_clock_i);
        wb_reset_i = 1'b0;
        check("t4_rst_scyc",  s_cycle_o, 1'b0);
        check("t4_rst_grant", grant_o,   2'b00);
        check("t4_rst_acks",  {m1_ack_o, m0_ack_o}, 2'b00);
        drv(0, 1'b1, 1'b1, 1'b0, 17'h041, 8'h00);
        @(negedge wb_clock_i);
        check("t4_tie_to_m0", grant_o, 2'b01);
        drv(0, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        stall = 1'b0;
        @(negedge wb_clock_i);
        check("t4_idle", grant_o, 2'b00);

        // Test 5: m1 waits while m0 owns the bus
        stall = 1'b1;
        drv(0, 1'b1, 1'b1, 1'b0, 17'h055, 8'h00);
        @(negedge wb_clock_i);
        check("t5_grant0", grant_o, 2'b01);
        drv(1, 1'b1, 1'b1, 1'b0, 17'h077, 8'h00);
        for (int k = 0; k < 3; k++) begin
            m0_addr_i = 17'(32'h100 + k);
            #1;
            check($sformatf("t5_track_addr_%0d", k), s_addr_o, 17'(32'h100 + k));
            check($sformatf("t5_m1_noack_%0d", k), m1_ack_o, 1'b0);
            @(negedge wb_clock_i);
        end
        drv(0, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        #1;
        check("t5_still_m0", grant_o, 2'b01);
        @(negedge wb_clock_i);
        check("t5_m1_grant", grant_o,  2'b10);
        check("t5_m1_addr",  s_addr_o, 17'h077);
        stall = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge wb_clock_i);
            if (m1_ack_o) ok = 1'b1;
        end
        check("t5_m1_ack", ok, 1'b1);
        drv(1, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        @(negedge wb_clock_i);
        check("t5_idle", grant_o, 2'b00);

`ifdef WB_ARBITER_TIMEOUT_EN
        // Test 6: stalled slave, watchdog returns all-ones after 16 cycles
        stall = 1'b1;
        drv(0, 1'b1, 1'b1, 1'b0, 17'h055, 8'h00);
        @(negedge wb_clock_i);
        check("t6_grant0", grant_o, 2'b01);
        n = -1;
        for (int i = 1; i <= 40 && n < 0; i++) begin
            @(negedge wb_clock_i);
            if (m0_ack_o) begin
                n = i;
                check("t6_data",    m0_data_o,  8'hFF);
                check("t6_scyc",    s_cycle_o,  1'b0);
                check("t6_sstb",    s_strobe_o, 1'b0);
                check("t6_flag",    timeout_o,  1'b1);
            end
        end
        check("t6_latency", n, 16);
        @(negedge wb_clock_i);
        check("t6_ack_pulse", m0_ack_o, 1'b0);
        check("t6_hold",      grant_o,  2'b01);
        drv(0, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        repeat (3) @(negedge wb_clock_i);
        check("t6_sticky", timeout_o, 1'b1);
        check("t6_idle",   grant_o,   2'b00);
        wb_reset_i = 1'b1;
        @(negedge wb_clock_i);
        wb_reset_i = 1'b0;
        check("t6_cleared", timeout_o, 1'b0);
        stall = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter directly upstream of the ram controller; its slave port drives the ram controller's wb_* inputs.
- Master 0 is the CPU bus bridge; master 1 is the MCU/SPI bridge.
- Grants whole bus cycles (cycle-held), round-robin on contention, and muxes address/data/we/strobe to the slave and ack/data back to the owner.

Parameters:
- DATA_WIDTH, 8, Wishbone data width
- ADDR_WIDTH, 17, Wishbone address width
- TIMEOUT_CYCLES, 16, ack watchdog limit; used only with WB_ARBITER_TIMEOUT_EN

Ports:
- wb_clock_i  in  1  single clock
- wb_reset_i  in  1  synchronous, active-high reset
- m0_addr_i / m1_addr_i  in  ADDR_WIDTH  master address
- m0_data_i / m1_data_i  in  DATA_WIDTH  master write data
- m0_data_o / m1_data_o  out  DATA_WIDTH  read data; both driven from s_data_i
- m0_we_i / m1_we_i  in  1  write enable
- m0_cycle_i / m1_cycle_i  in  1  bus request, held for the whole transfer
- m0_strobe_i / m1_strobe_i  in  1  transfer strobe
- m0_ack_o / m1_ack_o  out  1  ack, only to the granted master
- s_addr_o  out  ADDR_WIDTH  to the ram controller
- s_data_o  out  DATA_WIDTH  to the ram controller
- s_data_i  in  DATA_WIDTH  from the ram controller
- s_we_o  out  1
- s_cycle_o  out  1
- s_strobe_o  out  1
- s_ack_i  in  1
- grant_o  out  2  one-hot current owner (bit0 = m0), for debug
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- FSM states: IDLE, GRANT0, GRANT1.
- Registered last_owner bit; reset value is 1, so m0 wins the first tie.
- Reset (synchronous, effective at the next edge, also mid-transfer): state=IDLE, last_owner=1, timeout_o=0.
- In IDLE: s_cycle_o=0, s_strobe_o=0, s_we_o=0, s_addr_o=0, s_data_o=0, both acks=0, grant_o=0.
- IDLE transitions:
  - Only m0_cycle_i sampled high -> GRANT0.
  - Only m1_cycle_i sampled high -> GRANT1.
  - Both high -> the master != last_owner.
  - Neither -> stay in IDLE.
- Grant latency: a cycle raised before edge N is granted from edge N; slave signals reflect it in the cycle after N.
- GRANTx outputs (combinational mux on state):
  - s_addr_o, s_data_o, s_we_o, s_strobe_o = mx_*.
  - s_cycle_o = mx_cycle_i.
  - mx_ack_o = s_ack_i; the other master's ack = 0.
  - grant_o = one-hot x.
- GRANTx exit: when mx_cycle_i is sampled low, last_owner <= x.
  - If the other master's cycle is high at that same edge, go directly to its GRANT state (no idle gap).
  - Otherwise go to IDLE.
- A master releasing and re-asserting cycle while the other is waiting loses to the waiter.
- Non-granted masters see ack=0 indefinitely; they simply wait, with no retry or error.
- Strobe asserted without cycle is ignored (no grant).
- Data width is passed through unchanged; no byte lanes.

Optional Feature:
- Macro WB_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and on each s_ack_i.
  - It increments each cycle the owner has strobe high without ack.
  - At TIMEOUT_CYCLES it returns a one-cycle ack to the owner with data = all ones, sets timeout_o (sticky until reset), and drops s_cycle_o/s_strobe_o for that cycle.
  - The grant is held until the owner releases cycle.
- Undefined: no counter; timeout_o tied 0; a stalled slave stalls the owner forever.

Decomposition:
- Package wb_arb_pkg: state enum (IDLE, GRANT0, GRANT1) and a localparam for the owner index width.
- Address/data widths stay as module parameters.
- One natural sub-module, wb_arb_rr_grant: the FSM plus last_owner, producing the one-hot grant.
- Data muxing stays in wb_arbiter2.

Test Plan:
- Test 1: m0 writes 0x055 <- 8'h55 then reads 0x055, m1 idle, ram plus mock ram behind the arbiter.
  - Read returns 8'h55.
  - grant_o=01 during both transfers.
  - m1_ack_o never asserted.
- Test 2: m0 and m1 raise cycle on the same edge after reset (m0 writes 0x10 <- 8'hA1, m1 writes 0x11 <- 8'hB2).
  - m0 is served first, then m1 with no IDLE cycle between.
  - Read-back: 0x10=A1, 0x11=B2.
- Test 3: both request repeatedly, 4 transfers each.
  - Grants strictly alternate 01,10,01,10,...
- Test 4: wb_reset_i pulsed for 1 cycle while GRANT1 is mid-transfer.
  - Next cycle: s_cycle_o=0, grant_o=00, no acks.
  - A subsequent simultaneous request is granted to m0.
- Test 5: m1 requests while m0 owns the bus.
  - m1_ack_o stays 0, and s_addr_o tracks m0_addr_i, until m0 drops cycle.
  - m1 is granted at the edge where m0_cycle_i is sampled low.
- Test 6 (WB_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave ack tied 0, m0 reads.
  - m0_ack_o pulses after 16 cycles with data 8'hFF.
  - timeout_o=1 and stays set until reset.
